pico_int_controller: RTL

- Multi-source interrupt controller in front of the pico processor's single pico_int_req/pico_int_ack pair.
- Latches rising edges from N_SRC peripheral lines and masks them. Drives the request and resolves fixed priority at acknowledge time.
- Holds the in-service source until the ISR writes end-of-interrupt.
- Its registers are mapped on the processor port bus at BASE_ADDR..BASE_ADDR+3.

---
 rtl/pico_int_controller.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/pico_int_controller.sv
// -----------------------------------------------------------------------------
// pico_int_controller
//   Multi-source interrupt controller for the pico processor. It latches
//   rising edges from N_SRC peripheral lines into PENDING and gates them with
//   MASK. It raises pico_int_req and resolves fixed priority (index 0 highest)
//   in the acknowledge cycle. The chosen source is held in service until the
//   ISR writes EOI.
//
//   Port-mapped registers (offset from BASE_ADDR):
//     +0 PENDING  R, write-1-to-clear
//     +1 MASK     R/W, 1 = enabled
//     +2 VECTOR   R, bit7 = valid, bits[2:0] = in-service id
//     +3 EOI      W, any write ends service (reads return 0)
//
//   Optional build macro: PICO_INT_LEVEL_EN
//     When defined, PENDING follows the registered irq_src level.
//     In that build W1C writes and the ack-time clear have no lasting effect.
// -----------------------------------------------------------------------------
module pico_int_controller #(
   parameter int                 N_SRC     = 8,
   parameter int                 D_WIDTH   = 8,
   parameter logic [D_WIDTH-1:0] BASE_ADDR = 8'hF0
) (
   input  logic               pico_clk,
   input  logic               pico_reset,
   input  logic [N_SRC-1:0]   irq_src,
   input  logic [D_WIDTH-1:0] pico_port_address,
   input  logic               pico_port_read,
   input  logic               pico_port_write,
   input  logic [D_WIDTH-1:0] port_wdata,
   output logic [D_WIDTH-1:0] port_rdata,
   output logic               port_rdata_oe,
   output logic               port_ready,
   output logic               pico_int_req,
   input  logic               pico_int_ack,
   output logic               in_service
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [N_SRC-1:0]     irq_prev_q, irq_prev_d;
   logic [N_SRC-1:0]     pending_q, pending_d;
   logic [N_SRC-1:0]     mask_q, mask_d;
   logic                 vec_valid_q, vec_valid_d;
   logic [2:0]           vec_id_q, vec_id_d;
   logic                 int_req_q, int_req_d;
   logic                 in_service_q, in_service_d;
   logic                 port_ready_q, port_ready_d;
   logic                 rdata_oe_q, rdata_oe_d;
   logic [D_WIDTH-1:0]   rdata_q, rdata_d;

   logic                 addr_hit_s;
   logic [1:0]           addr_off_s;
   logic                 wr_s;
   logic                 rd_s;
   logic                 wr_pending_s;
   logic                 wr_mask_s;
   logic                 wr_eoi_s;
   logic [N_SRC-1:0]     active_s;
   logic [2:0]           sel_id_s;
   logic                 ack_clear_s;
   logic [D_WIDTH-1:0]   rd_value_s;

   // Address decode: the block owns the 4-aligned window starting at BASE_ADDR.
   // A simultaneous read and write counts as a write only.
   always_comb begin
      addr_hit_s   = (pico_port_address[D_WIDTH-1:2] == BASE_ADDR[D_WIDTH-1:2]);
      addr_off_s   = pico_port_address[1:0];
      wr_s         = pico_port_write & addr_hit_s;
      rd_s         = pico_port_read & ~pico_port_write & addr_hit_s;
      wr_pending_s = wr_s & (addr_off_s == 2'd0);
      wr_mask_s    = wr_s & (addr_off_s == 2'd1);
      wr_eoi_s     = wr_s & (addr_off_s == 2'd3);
   end

   // Read-data mux; unused upper bits and the EOI slot read as zero.
   always_comb begin
      rd_value_s = {D_WIDTH{1'b0}};
      case (addr_off_s)
         2'd0: rd_value_s[N_SRC-1:0] = pending_q;
         2'd1: rd_value_s[N_SRC-1:0] = mask_q;
         2'd2: begin
            rd_value_s[7]   = vec_valid_q;
            rd_value_s[2:0] = vec_id_q;
         end
         2'd3: rd_value_s = {D_WIDTH{1'b0}};
         default: rd_value_s = {D_WIDTH{1'b0}};
      endcase
   end

   // Fixed priority: scan from the top so the lowest set index is the last one written.
   always_comb begin
      active_s = pending_q & mask_q;
      sel_id_s = 3'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (active_s[i]) begin
            sel_id_s = 3'(i);
         end else begin
            sel_id_s = sel_id_s;
         end
      end
   end

   // Controller FSM: request while anything enabled is pending, then lock one source until EOI.
   always_comb begin
      state_d     = state_q;
      vec_valid_d = vec_valid_q;
      vec_id_d    = vec_id_q;
      ack_clear_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|active_s) begin
               state_d = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (~|active_s) begin
               // Cause withdrawn (W1C or mask) before the processor answered.
               state_d = ST_IDLE;
            end else if (pico_int_ack) begin
               state_d     = ST_SERVICE;
               vec_valid_d = 1'b1;
               vec_id_d    = sel_id_s;
               ack_clear_s = 1'b1;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_SERVICE: begin
            if (wr_eoi_s) begin
               state_d     = ST_IDLE;
               vec_valid_d = 1'b0;
            end else begin
               state_d = ST_SERVICE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            vec_valid_d = 1'b0;
            vec_id_d    = 3'd0;
         end
      endcase
      int_req_d    = (state_d == ST_REQ);
      in_service_d = (state_d == ST_SERVICE);
   end

   // Pending/mask/edge-history update; a fresh edge beats a same-cycle clear.
   always_comb begin
      irq_prev_d = irq_src;
      if (wr_mask_s) begin
         mask_d = port_wdata[N_SRC-1:0];
      end else begin
         mask_d = mask_q;
      end
`ifdef PICO_INT_LEVEL_EN
      pending_d = irq_src;
`else
      pending_d = pending_q;
      if (wr_pending_s) begin
         pending_d = pending_d & ~port_wdata[N_SRC-1:0];
      end else begin
         pending_d = pending_d;
      end
      for (int i = 0; i < N_SRC; i++) begin
         if (ack_clear_s && (sel_id_s == 3'(i))) begin
            pending_d[i] = 1'b0;
         end else begin
            pending_d[i] = pending_d[i];
         end
      end
      pending_d = pending_d | (irq_src & ~irq_prev_q);
`endif
   end

   // Bus response: one-cycle ready after a mapped strobe, data driven only for reads.
   always_comb begin
      port_ready_d = addr_hit_s & (pico_port_read | pico_port_write);
      rdata_oe_d   = rd_s;
      if (rd_s) begin
         rdata_d = rd_value_s;
      end else begin
         rdata_d = {D_WIDTH{1'b0}};
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge pico_clk or negedge pico_reset) begin
      if (!pico_reset) begin
         state_q      <= ST_IDLE;
         irq_prev_q   <= {N_SRC{1'b0}};
         pending_q    <= {N_SRC{1'b0}};
         mask_q       <= {N_SRC{1'b0}};
         vec_valid_q  <= 1'b0;
         vec_id_q     <= 3'd0;
         int_req_q    <= 1'b0;
         in_service_q <= 1'b0;
         port_ready_q <= 1'b0;
         rdata_oe_q   <= 1'b0;
         rdata_q      <= {D_WIDTH{1'b0}};
      end else begin
         state_q      <= state_d;
         irq_prev_q   <= irq_prev_d;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         vec_valid_q  <= vec_valid_d;
         vec_id_q     <= vec_id_d;
         int_req_q    <= int_req_d;
         in_service_q <= in_service_d;
         port_ready_q <= port_ready_d;
         rdata_oe_q   <= rdata_oe_d;
         rdata_q      <= rdata_d;
      end
   end

   assign port_rdata    = rdata_q;
   assign port_rdata_oe = rdata_oe_q;
   assign port_ready    = port_ready_q;
   assign pico_int_req  = int_req_q;
   assign in_service    = in_service_q;

endmodule
